cdb_writeback_arbiter: RTL and testbench
========================================

// Module: cdb_writeback_arbiter
// PURPOSE
//  Shares the single result/common data bus (CDB) between the execution units (ALU, MEM, MUL, DIV, FPU).
//  Each unit pushes completed results into its own 2-entry FIFO inside this block.
//  A round-robin arbiter grants one FIFO head per cycle onto a registered CDB.
//  The CDB feeds the PRF write port, the IQ wakeup, the ROB done-marking and the bypass network.
// PARAMETERS
//  NUM_FU      5                  number of requesting units; index = fu_type (0=ALU,1=MEM,2=MUL,3=DIV,4=FPU)
//  DATA_W      INT_DATA_W (32)    result width
//  PREG_W      PHYS_REG_IDX_W (6) physical destination tag width
//  ROBI_W      ROB_IDX_W (4)      ROB index width
// PORTS
//  clk            in   1               core clock; all state updates on rising edge
//  rst_n          in   1               asynchronous active-low reset
//  flush          in   1               mispredict/exception flush; synchronous clear
//  fu_valid       in   NUM_FU          unit i presents a result
//  fu_ready       out  NUM_FU          FIFO i can accept (registered)
//  fu_phys_rd     in   NUM_FU*PREG_W   dest tag, slice i = [i*PREG_W +: PREG_W]
//  fu_result      in   NUM_FU*DATA_W   result value, slice i as above
//  fu_rob_idx     in   NUM_FU*ROBI_W   ROB index, slice i as above
//  cdb_valid      out  1               CDB carries a result this cycle
//  cdb_fu         out  3               index of the unit that won
//  cdb_phys_rd    out  PREG_W          broadcast tag
//  cdb_result     out  DATA_W          broadcast value
//  cdb_rob_idx    out  ROBI_W          ROB entry to mark done
//  pending        out  1               any FIFO non-empty (used for drain detection)
// BEHAVIOUR
//  Reset (rst_n=0, async)
//   - All FIFO counts and pointers clear; rr_ptr=0.
//   - cdb_valid=0; cdb_fu/phys_rd/result/rob_idx=0; fu_ready=all 1s; pending=0.
//  Push
//   - fu_ready[i] = (count[i] < 2), computed from registered count only.
//   - Entry {phys_rd, result, rob_idx} is written when fu_valid[i] && fu_ready[i].
//   - fu_valid while not ready is ignored; the unit must hold its result.
//  Arbitration (combinational on FIFO heads, in the same cycle)
//   - Requesters are FIFOs with count[i] != 0.
//   - Winner = first requester scanning from rr_ptr upward, wrapping at NUM_FU-1 -> 0.
//   - On a grant: winner head is popped; rr_ptr <= (winner+1) mod NUM_FU.
//   - No requesters: rr_ptr holds.
//  CDB register
//   - At each edge, cdb_* <= winner head and cdb_valid <= grant.
//   - Fields are 0 when there is no grant.
//   - There is no CDB backpressure; consumers always accept.
//  Latency
//   - Push accepted at edge N -> earliest cdb_valid in the cycle after edge N+1.
//   - Throughput: 1 result/cycle overall; 1/cycle per unit when uncontended.
//  Boundary cases
//   - Push and pop on the same FIFO in one cycle: count unchanged, and the order is kept.
//   - Count=0: a same-cycle push is not visible to the arbiter until the next cycle (no FIFO fall-through).
//   - Count=2: fu_ready=0; the pop in that cycle frees one slot, visible next cycle.
//   - Fairness: any non-empty FIFO is granted within NUM_FU cycles.
//   - flush=1: all counts clear, cdb_valid<=0 and pushes that cycle are dropped.
//     rr_ptr is kept. flush overrides push and pop.
//   - Reset asserted mid-operation: immediate clear as in reset; queued results are lost.
//  pending = OR of (count[i]!=0), combinational from registered state.
// TESTING
//  1 Reset: hold rst_n=0 with all fu_valid=1 -> cdb_valid=0, fu_ready=5'b11111, pending=0.
//  2 Single: ALU pushes tag 7, result 0xDEADBEEF, rob 3 at edge N
//    -> cycle after N+1 shows cdb_valid=1, cdb_fu=0, phys_rd=7, result=0xDEADBEEF, rob_idx=3.
//  3 Contention: all 5 units push 1 result in the same cycle with rr_ptr=0
//    -> CDB order 0,1,2,3,4 over 5 consecutive cycles, then cdb_valid=0.
//  4 Backpressure: MUL pushes 3 back-to-back while ALU saturates CDB priority
//    -> fu_ready[2]=0 after 2 accepted; FIFO order kept; no result lost.
//  5 Flush: 3 results queued, flush=1 for one cycle
//    -> next cycle cdb_valid=0, pending=0, fu_ready all 1, no stale broadcast.
//  6 Wrap/fairness: FIFOs 4 and 0 both non-empty with rr_ptr=4
//    -> grant 4 then 0, and rr_ptr becomes 1.

Source files
------------

// File: rtl/cdb_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_writeback_arbiter
//
// Shares the single common data bus (CDB) between the execution units
// (0=ALU, 1=MEM, 2=MUL, 3=DIV, 4=FPU). Each unit pushes completed results into
// its own 2-entry FIFO. A round-robin arbiter picks one non-empty FIFO head per
// cycle and drives it onto a registered CDB. The CDB feeds the PRF write port,
// IQ wakeup, ROB done-marking and the bypass network.
//
// Ports
//   clk          core clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   flush        synchronous clear of all queued results (mispredict/exception)
//   fu_valid     per-unit result present
//   fu_ready     per-unit FIFO has room (derived from registered count only)
//   fu_phys_rd   per-unit destination tag, slice i = [i*PREG_W +: PREG_W]
//   fu_result    per-unit result value, slice i = [i*DATA_W +: DATA_W]
//   fu_rob_idx   per-unit ROB index, slice i = [i*ROBI_W +: ROBI_W]
//   cdb_valid    CDB carries a result this cycle
//   cdb_fu       index of the unit whose result is on the CDB
//   cdb_phys_rd  broadcast tag
//   cdb_result   broadcast value
//   cdb_rob_idx  ROB entry to mark done
//   pending      at least one FIFO is non-empty
//
// Handshake: a push happens on a rising edge where fu_valid[i] && fu_ready[i].
// fu_valid while fu_ready is low is ignored and the unit must keep presenting
// the same result. The CDB itself has no backpressure: every broadcast is
// consumed in the cycle it is shown.
// -----------------------------------------------------------------------------
module cdb_writeback_arbiter #(
   parameter int NUM_FU = 5,
   parameter int DATA_W = 32,
   parameter int PREG_W = 6,
   parameter int ROBI_W = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic [NUM_FU-1:0]        fu_valid,
   output logic [NUM_FU-1:0]        fu_ready,
   input  logic [NUM_FU*PREG_W-1:0] fu_phys_rd,
   input  logic [NUM_FU*DATA_W-1:0] fu_result,
   input  logic [NUM_FU*ROBI_W-1:0] fu_rob_idx,
   output logic                     cdb_valid,
   output logic [2:0]               cdb_fu,
   output logic [PREG_W-1:0]        cdb_phys_rd,
   output logic [DATA_W-1:0]        cdb_result,
   output logic [ROBI_W-1:0]        cdb_rob_idx,
   output logic                     pending
);

   localparam int ENT_W = PREG_W + DATA_W + ROBI_W;

   // Per-unit FIFO state: two slots, one-bit read/write pointers, 0..2 count.
   logic [ENT_W-1:0]  mem    [NUM_FU][2];
   logic [NUM_FU-1:0] wr_ptr;
   logic [NUM_FU-1:0] rd_ptr;
   logic [1:0]        count  [NUM_FU];
   logic [2:0]        rr_ptr;

   logic [ENT_W-1:0]  ent_in [NUM_FU];
   logic [NUM_FU-1:0] req;
   logic [NUM_FU-1:0] push;
   logic [NUM_FU-1:0] pop;

   logic              grant;
   logic [2:0]        win;
   logic [3:0]        scan_sum;
   logic [2:0]        scan_idx;
   logic [ENT_W-1:0]  head;

   // Ready, request and push qualification all come from registered counts,
   // so a slot freed by this cycle's pop only shows up next cycle.
   always_comb begin
      for (int i = 0; i < NUM_FU; i++) begin
         fu_ready[i] = (count[i] != 2'd2);
         req[i]      = (count[i] != 2'd0);
         push[i]     = fu_valid[i] && (count[i] != 2'd2);
         ent_in[i]   = {fu_phys_rd[i*PREG_W +: PREG_W],
                        fu_result[i*DATA_W +: DATA_W],
                        fu_rob_idx[i*ROBI_W +: ROBI_W]};
      end
   end

   assign pending = |req;

   // Round-robin scan starting at rr_ptr, wrapping NUM_FU-1 -> 0; the first
   // non-empty FIFO met wins.
   always_comb begin
      grant    = 1'b0;
      win      = 3'd0;
      scan_sum = 4'd0;
      scan_idx = 3'd0;
      for (int k = 0; k < NUM_FU; k++) begin
         scan_sum = {1'b0, rr_ptr} + 4'(k);
         if (scan_sum >= 4'(NUM_FU)) begin
            scan_sum = scan_sum - 4'(NUM_FU);
         end
         scan_idx = scan_sum[2:0];
         if (!grant && req[scan_idx]) begin
            grant = 1'b1;
            win   = scan_idx;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_FU; i++) begin
         pop[i] = grant && (win == 3'(i));
      end
   end

   assign head = mem[win][rd_ptr[win]];

   // Payload storage carries no reset; validity is tracked by count alone.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_FU; i++) begin
         if (!flush && push[i]) begin
            mem[i][wr_ptr[i]] <= ent_in[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         rr_ptr      <= 3'd0;
         cdb_valid   <= 1'b0;
         cdb_fu      <= 3'd0;
         cdb_phys_rd <= '0;
         cdb_result  <= '0;
         cdb_rob_idx <= '0;
         for (int i = 0; i < NUM_FU; i++) begin
            count[i] <= 2'd0;
         end
      end else if (flush) begin
         // Flush drops queued results and this cycle's pushes; rr_ptr is kept
         // so fairness history survives the flush.
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         cdb_valid   <= 1'b0;
         cdb_fu      <= 3'd0;
         cdb_phys_rd <= '0;
         cdb_result  <= '0;
         cdb_rob_idx <= '0;
         for (int i = 0; i < NUM_FU; i++) begin
            count[i] <= 2'd0;
         end
      end else begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (push[i]) begin
               wr_ptr[i] <= ~wr_ptr[i];
            end
            if (pop[i]) begin
               rd_ptr[i] <= ~rd_ptr[i];
            end
            case ({push[i], pop[i]})
               2'b10:   count[i] <= count[i] + 2'd1;
               2'b01:   count[i] <= count[i] - 2'd1;
               default: count[i] <= count[i];
            endcase
         end
         cdb_valid <= grant;
         if (grant) begin
            cdb_fu      <= win;
            cdb_phys_rd <= head[ENT_W-1 -: PREG_W];
            cdb_result  <= head[ROBI_W +: DATA_W];
            cdb_rob_idx <= head[ROBI_W-1:0];
            rr_ptr      <= (win == 3'(NUM_FU-1)) ? 3'd0 : win + 3'd1;
         end else begin
            cdb_fu      <= 3'd0;
            cdb_phys_rd <= '0;
            cdb_result  <= '0;
            cdb_rob_idx <= '0;
         end
      end
   end

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_writeback_arbiter
//
// Directed bench for cdb_writeback_arbiter. A table of per-cycle records holds
// the inputs applied before an edge and the outputs expected just after it.
// Payloads are encoded from (unit, sequence number) so every broadcast can be
// traced back to the push that produced it. Reset, the single-result latency
// case and an asynchronous mid-run reset are written out by hand.
// -----------------------------------------------------------------------------
module tb_cdb_writeback_arbiter;

   localparam int NUM_FU = 5;
   localparam int DATA_W = 32;
   localparam int PREG_W = 6;
   localparam int ROBI_W = 4;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic                     flush;
   logic [NUM_FU-1:0]        fu_valid;
   logic [NUM_FU-1:0]        fu_ready;
   logic [NUM_FU*PREG_W-1:0] fu_phys_rd;
   logic [NUM_FU*DATA_W-1:0] fu_result;
   logic [NUM_FU*ROBI_W-1:0] fu_rob_idx;
   logic                     cdb_valid;
   logic [2:0]               cdb_fu;
   logic [PREG_W-1:0]        cdb_phys_rd;
   logic [DATA_W-1:0]        cdb_result;
   logic [ROBI_W-1:0]        cdb_rob_idx;
   logic                     pending;

   cdb_writeback_arbiter #(
      .NUM_FU(NUM_FU), .DATA_W(DATA_W), .PREG_W(PREG_W), .ROBI_W(ROBI_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .fu_valid(fu_valid), .fu_ready(fu_ready),
      .fu_phys_rd(fu_phys_rd), .fu_result(fu_result), .fu_rob_idx(fu_rob_idx),
      .cdb_valid(cdb_valid), .cdb_fu(cdb_fu), .cdb_phys_rd(cdb_phys_rd),
      .cdb_result(cdb_result), .cdb_rob_idx(cdb_rob_idx), .pending(pending)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // payload encoding from (unit, seq)
   function automatic logic [PREG_W-1:0] p_tag(int u, int s);
      return PREG_W'(u * 8 + s);
   endfunction
   function automatic logic [DATA_W-1:0] p_res(int u, int s);
      return 32'hC0DE_0000 + DATA_W'(u * 256 + s);
   endfunction
   function automatic logic [ROBI_W-1:0] p_rob(int u, int s);
      return ROBI_W'(u * 3 + s);
   endfunction

   // scoreboard check
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // driver tasks
   task automatic drive(logic [NUM_FU-1:0] v, int seq, logic fl);
      fu_valid = v;
      flush    = fl;
      for (int u = 0; u < NUM_FU; u++) begin
         fu_phys_rd[u*PREG_W +: PREG_W] = p_tag(u, seq);
         fu_result[u*DATA_W +: DATA_W]  = p_res(u, seq);
         fu_rob_idx[u*ROBI_W +: ROBI_W] = p_rob(u, seq);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_cdb(string tag, logic v, int fu, int s);
      chk({tag, " cdb_valid"},   32'(cdb_valid),   32'(v));
      chk({tag, " cdb_fu"},      32'(cdb_fu),      v ? 32'(fu) : 32'd0);
      chk({tag, " cdb_phys_rd"}, 32'(cdb_phys_rd), v ? 32'(p_tag(fu, s)) : 32'd0);
      chk({tag, " cdb_result"},  32'(cdb_result),  v ? 32'(p_res(fu, s)) : 32'd0);
      chk({tag, " cdb_rob_idx"}, 32'(cdb_rob_idx), v ? 32'(p_rob(fu, s)) : 32'd0);
   endtask

   typedef struct {
      logic [NUM_FU-1:0] valid;
      logic              flush;
      int                seq;
      logic              exp_v;
      int                exp_fu;
      int                exp_seq;
      logic [NUM_FU-1:0] exp_ready;
      logic              exp_pend;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic [NUM_FU-1:0] valid, logic fl, int seq,
                               logic ev, int efu, int eseq,
                               logic [NUM_FU-1:0] erdy, logic epend);
      vec_t r;
      r.valid = valid; r.flush = fl; r.seq = seq;
      r.exp_v = ev; r.exp_fu = efu; r.exp_seq = eseq;
      r.exp_ready = erdy; r.exp_pend = epend;
      return r;
   endfunction

   initial begin
      // contention from rr_ptr=0: order 0..4 then idle
      vecs.push_back(mk(5'b11111, 0, 1, 0, 0, 0, 5'b11111, 1));
      vecs.push_back(mk(5'b00000, 0, 0, 1, 0, 1, 5'b11111, 1));
      vecs.push_back(mk(5'b00000, 0, 0, 1, 1, 1, 5'b11111, 1));
      vecs.push_back(mk(5'b00000, 0, 0, 1, 2, 1, 5'b11111, 1));
      vecs.push_back(mk(5'b00000, 0, 0, 1, 3, 1, 5'b11111, 1));
      vecs.push_back(mk(5'b00000, 0, 0, 1, 4, 1, 5'b11111, 0));
      vecs.push_back(mk(5'b00000, 0, 0, 0, 0, 0, 5'b11111, 0));
      // grant 3 moves rr_ptr to 4, then wrap 4 -> 0
      vecs.push_back(mk(5'b01000, 0, 2, 0, 0, 0, 5'b11111, 1));
      vecs.push_back(mk(5'b10001, 0, 3, 1, 3, 2, 5'b11111, 1));
      vecs.push_back(mk(5'b00000, 0, 0, 1, 4, 3, 5'b11111, 1));
      vecs.push_back(mk(5'b00000, 0, 0, 1, 0, 3, 5'b11111, 0));
      // rr_ptr now 1: unit 2 must beat unit 0
      vecs.push_back(mk(5'b00101, 0, 4, 0, 0, 0, 5'b11111, 1));
      vecs.push_back(mk(5'b00000, 0, 0, 1, 2, 4, 5'b11111, 1));
      vecs.push_back(mk(5'b00000, 0, 0, 1, 0, 4, 5'b11111, 0));
      // uncontended unit: push and pop same cycle, 1 result per cycle
      vecs.push_back(mk(5'b00010, 0, 5, 0, 0, 0, 5'b11111, 1));
      vecs.push_back(mk(5'b00010, 0, 6, 1, 1, 5, 5'b11111, 1));
      vecs.push_back(mk(5'b00010, 0, 7, 1, 1, 6, 5'b11111, 1));
      vecs.push_back(mk(5'b00000, 0, 0, 1, 1, 7, 5'b11111, 0));
      vecs.push_back(mk(5'b00000, 0, 0, 0, 0, 0, 5'b11111, 0));
      // ALU and MUL contend: both FIFOs fill, extra pushes ignored, order kept
      vecs.push_back(mk(5'b00101, 0, 1, 0, 0, 0, 5'b11111, 1));
      vecs.push_back(mk(5'b00101, 0, 2, 1, 2, 1, 5'b11110, 1));
      vecs.push_back(mk(5'b00101, 0, 3, 1, 0, 1, 5'b11011, 1));
      vecs.push_back(mk(5'b00100, 0, 4, 1, 2, 2, 5'b11111, 1));
      vecs.push_back(mk(5'b00000, 0, 0, 1, 0, 2, 5'b11111, 1));
      vecs.push_back(mk(5'b00000, 0, 0, 1, 2, 3, 5'b11111, 0));
      vecs.push_back(mk(5'b00000, 0, 0, 0, 0, 0, 5'b11111, 0));
      // flush with three queued results and concurrent pushes
      vecs.push_back(mk(5'b00111, 0, 5, 0, 0, 0, 5'b11111, 1));
      vecs.push_back(mk(5'b11000, 1, 6, 0, 0, 0, 5'b11111, 0));
      vecs.push_back(mk(5'b00000, 0, 0, 0, 0, 0, 5'b11111, 0));
      // rr_ptr survived the flush (3): unit 4 beats unit 0
      vecs.push_back(mk(5'b10001, 0, 7, 0, 0, 0, 5'b11111, 1));
      vecs.push_back(mk(5'b00000, 0, 0, 1, 4, 7, 5'b11111, 1));
      vecs.push_back(mk(5'b00000, 0, 0, 1, 0, 7, 5'b11111, 0));
      vecs.push_back(mk(5'b00000, 0, 0, 0, 0, 0, 5'b11111, 0));

      // reset held with all units valid
      drive(5'b11111, 1, 1'b0);
      step();
      step();
      chk_cdb("reset", 1'b0, 0, 0);
      chk("reset fu_ready", 32'(fu_ready), 32'h1F);
      chk("reset pending",  32'(pending),  32'd0);
      rst_n = 1'b1;
      drive(5'b00000, 0, 1'b0);
      step();

      // table
      for (int r = 0; r < vecs.size(); r++) begin
         drive(vecs[r].valid, vecs[r].seq, vecs[r].flush);
         step();
         chk_cdb($sformatf("row%0d", r), vecs[r].exp_v, vecs[r].exp_fu, vecs[r].exp_seq);
         chk($sformatf("row%0d fu_ready", r), 32'(fu_ready), 32'(vecs[r].exp_ready));
         chk($sformatf("row%0d pending", r),  32'(pending),  32'(vecs[r].exp_pend));
      end

      // single ALU result: visible the cycle after edge N+1
      drive(5'b00000, 0, 1'b0);
      fu_valid[0]       = 1'b1;
      fu_phys_rd[5:0]   = 6'd7;
      fu_result[31:0]   = 32'hDEAD_BEEF;
      fu_rob_idx[3:0]   = 4'd3;
      step();
      chk("single edgeN cdb_valid", 32'(cdb_valid), 32'd0);
      chk("single edgeN pending",   32'(pending),   32'd1);
      drive(5'b00000, 0, 1'b0);
      step();
      chk("single cdb_valid",   32'(cdb_valid),   32'd1);
      chk("single cdb_fu",      32'(cdb_fu),      32'd0);
      chk("single cdb_phys_rd", 32'(cdb_phys_rd), 32'd7);
      chk("single cdb_result",  32'(cdb_result),  32'hDEAD_BEEF);
      chk("single cdb_rob_idx", 32'(cdb_rob_idx), 32'd3);
      chk("single pending",     32'(pending),     32'd0);

      // asynchronous reset mid-operation
      drive(5'b00100, 1, 1'b0);
      step();
      drive(5'b10001, 2, 1'b0);
      step();
      chk_cdb("prereset", 1'b1, 2, 1);
      drive(5'b00000, 0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_cdb("asyncrst", 1'b0, 0, 0);
      chk("asyncrst fu_ready", 32'(fu_ready), 32'h1F);
      chk("asyncrst pending",  32'(pending),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("postrst pending", 32'(pending), 32'd0);
      // rr_ptr back at 0: unit 0 first, then 4
      drive(5'b10001, 3, 1'b0);
      step();
      drive(5'b00000, 0, 1'b0);
      step();
      chk_cdb("postrst first", 1'b1, 0, 3);
      step();
      chk_cdb("postrst second", 1'b1, 4, 3);
      step();
      chk_cdb("postrst idle", 1'b0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
